// File: rtl/painterengine_gpu_blendctrl_pkg.sv
// painterengine_gpu_blendctrl_pkg
// Shared definitions for the blend controller and its arithmetic core:
//   - state_t   : 2-bit controller state encoding
//   - DIM_W     : width of the rectangle dimension / coordinate fields
//   - *_LSB     : bit offsets of the ARGB fields inside a 32-bit pixel
//   - CH_W      : width of one colour/alpha channel
package painterengine_gpu_blendctrl_pkg;

   localparam int DIM_W = 16;
   localparam int PIX_W = 32;
   localparam int CH_W  = 8;

   localparam int A_LSB = 24;
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/painterengine_gpu_alphablend.sv
// painterengine_gpu_alphablend
// Purely combinational source-over blend of one ARGB pixel pair.
// All intermediate arithmetic is 16 bits wide; results are bits [15:8].
// Ports:
//   src_a/src_r/src_g/src_b : foreground pixel channels (a1, c1)
//   dst_a/dst_r/dst_g/dst_b : background pixel channels (a2, c2)
//   out_a/out_r/out_g/out_b : blended pixel channels
module painterengine_gpu_alphablend
   import painterengine_gpu_blendctrl_pkg::*;
(
   input  logic [7:0] src_a,
   input  logic [7:0] src_r,
   input  logic [7:0] src_g,
   input  logic [7:0] src_b,
   input  logic [7:0] dst_a,
   input  logic [7:0] dst_r,
   input  logic [7:0] dst_g,
   input  logic [7:0] dst_b,
   output logic [7:0] out_a,
   output logic [7:0] out_r,
   output logic [7:0] out_g,
   output logic [7:0] out_b
);

   // 256-a1 weights the background, a1+1 weights the foreground; the two
   // weights always sum to 257, so the 16-bit sums can never overflow.
   logic [15:0] inv_a1;
   logic [15:0] fg_w;
   logic [15:0] alpha_prod;

   assign inv_a1     = 16'd256 - {8'd0, src_a};
   assign fg_w       = {8'd0, src_a} + 16'd1;
   assign alpha_prod = inv_a1 * (16'd255 - {8'd0, dst_a});
   assign out_a      = 8'd255 - alpha_prod[15:8];

   // Colour channels share one formula; index 0..2 = r, g, b.
   logic [CH_W-1:0] c1 [3];
   logic [CH_W-1:0] c2 [3];
   logic [CH_W-1:0] co [3];

   assign c1[0] = src_r;
   assign c1[1] = src_g;
   assign c1[2] = src_b;
   assign c2[0] = dst_r;
   assign c2[1] = dst_g;
   assign c2[2] = dst_b;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [15:0] mix;
         assign mix    = inv_a1 * {8'd0, c2[gi]} + {8'd0, c1[gi]} * fg_w;
         assign co[gi] = mix[15:8];
      end
   endgenerate

   assign out_r = co[0];
   assign out_g = co[1];
   assign out_b = co[2];

endmodule

// File: rtl/painterengine_gpu_blendctrl.sv
// painterengine_gpu_blendctrl
// Walks a width x height rectangle, consuming one source and one destination
// pixel together per cycle, blending them and presenting the result through a
// single-entry output register with valid/ready flow control.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   start, width, height    : job start (accepted in IDLE) and dimensions
//   busy, done              : busy in RUN/DRAIN, one-cycle done pulse
//   src_valid/ready/data    : foreground pixel stream
//   dst_valid/ready/data    : background pixel stream
//   out_valid/ready/data    : blended pixel stream
//   px_x, px_y              : coordinate of the next pixel pair to consume
module painterengine_gpu_blendctrl
   import painterengine_gpu_blendctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       width,
   input  logic [15:0]       height,
   output logic              busy,
   output logic              done,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [31:0]       src_data,
   input  logic              dst_valid,
   output logic              dst_ready,
   input  logic [31:0]       dst_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [15:0]       px_x,
   output logic [15:0]       px_y
);

   state_t            state_reg;
   state_t            state_next;
   logic [DIM_W-1:0]  width_reg;
   logic [DIM_W-1:0]  height_reg;
   logic [DIM_W-1:0]  px_x_reg;
   logic [DIM_W-1:0]  px_y_reg;
   logic              out_valid_reg;
   logic [PIX_W-1:0]  out_data_reg;

   logic              fire;
   logic              last_col;
   logic              last_px;
   logic [PIX_W-1:0]  blend_px;

   // A pair is consumed only when both inputs are present and the output
   // register is empty or being drained in this same cycle.
   assign fire     = (state_reg == ST_RUN) && src_valid && dst_valid &&
                     (!out_valid_reg || out_ready);
   assign last_col = (px_x_reg == width_reg - 16'd1);
   assign last_px  = last_col && (px_y_reg == height_reg - 16'd1);

   assign src_ready = fire;
   assign dst_ready = fire;
   assign busy      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
   assign done      = (state_reg == ST_DONE);
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign px_x      = px_x_reg;
   assign px_y      = px_y_reg;

   painterengine_gpu_alphablend u_blend (
      .src_a (src_data[A_LSB +: CH_W]),
      .src_r (src_data[R_LSB +: CH_W]),
      .src_g (src_data[G_LSB +: CH_W]),
      .src_b (src_data[B_LSB +: CH_W]),
      .dst_a (dst_data[A_LSB +: CH_W]),
      .dst_r (dst_data[R_LSB +: CH_W]),
      .dst_g (dst_data[G_LSB +: CH_W]),
      .dst_b (dst_data[B_LSB +: CH_W]),
      .out_a (blend_px[A_LSB +: CH_W]),
      .out_r (blend_px[R_LSB +: CH_W]),
      .out_g (blend_px[G_LSB +: CH_W]),
      .out_b (blend_px[B_LSB +: CH_W])
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               // Empty rectangle: nothing to consume, report completion.
               if (width == 16'd0 || height == 16'd0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (fire && last_px) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Finish once the final output has left (or is leaving now).
            if (!out_valid_reg || out_ready) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         width_reg     <= '0;
         height_reg    <= '0;
         px_x_reg      <= '0;
         px_y_reg      <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         if (state_reg == ST_IDLE && start) begin
            width_reg  <= width;
            height_reg <= height;
            px_x_reg   <= '0;
            px_y_reg   <= '0;
         end

         if (fire) begin
            if (last_col) begin
               px_x_reg <= '0;
               px_y_reg <= px_y_reg + 16'd1;
            end else begin
               px_x_reg <= px_x_reg + 16'd1;
            end
         end

         // A fire overrides a concurrent drain: the old word is taken by the
         // sink and the register is reloaded in the same edge.
         if (fire) begin
            out_data_reg  <= blend_px;
            out_valid_reg <= 1'b1;
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_painterengine_gpu_blendctrl.sv
module tb_painterengine_gpu_blendctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] width;
   logic [15:0] height;
   logic        busy;
   logic        done;
   logic        src_valid;
   logic        src_ready;
   logic [31:0] src_data;
   logic        dst_valid;
   logic        dst_ready;
   logic [31:0] dst_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [15:0] px_x;
   logic [15:0] px_y;

   int checks = 0;
   int passed = 0;
   logic [31:0] out_q [$];

   always #5 clk = ~clk;

   painterengine_gpu_blendctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .width     (width),
      .height    (height),
      .busy      (busy),
      .done      (done),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_data  (src_data),
      .dst_valid (dst_valid),
      .dst_ready (dst_ready),
      .dst_data  (dst_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .px_x      (px_x),
      .px_y      (px_y)
   );

   // Runs one job and records every output handshake into out_q. Inputs
   // change at posedge+1 and outputs are sampled at posedge+2.
   task automatic drive_job(input logic [15:0] w, input logic [15:0] h,
                            input logic [31:0] sp, input logic [31:0] dp,
                            input bit inc, input int stall_at, input int stall_len,
                            output int n_out, output bit saw_done,
                            output bit timed_out, output bit stall_ok,
                            output int n_stalled);
      int consumed;
      int total;
      logic [31:0] held;
      bit held_v;
      out_q.delete();
      saw_done  = 0;
      timed_out = 1;
      stall_ok  = 1;
      n_stalled = 0;
      consumed  = 0;
      total     = int'(w) * int'(h);
      held_v    = 0;
      held      = '0;
      @(posedge clk); #1;
      start = 1; width = w; height = h;
      src_valid = 0; dst_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      start = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         src_valid = (consumed < total);
         dst_valid = (consumed < total);
         src_data  = inc ? sp + 32'(consumed) : sp;
         dst_data  = dp;
         out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         #1;
         if (done) begin
            saw_done  = 1;
            timed_out = 0;
            break;
         end
         if (!out_ready && out_valid) begin
            n_stalled++;
            if (src_ready || dst_ready) stall_ok = 0;
            if (held_v && out_data !== held) stall_ok = 0;
            held   = out_data;
            held_v = 1;
         end else begin
            held_v = 0;
         end
         if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            $display("out[%0d] = %08h", out_q.size() - 1, out_data);
         end
         if (src_ready) consumed++;
         @(posedge clk); #1;
      end
      src_valid = 0; dst_valid = 0; out_ready = 1;
      n_out = out_q.size();
   endtask

   task automatic test_reset;
      rst = 1; start = 0; width = 0; height = 0;
      src_valid = 1; dst_valid = 1; src_data = 32'hFFFFFFFF; dst_data = 32'hFFFFFFFF;
      out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
      checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %08h want 00000000", out_data); else passed++;
      checks++; if (src_ready !== 1'b0 || dst_ready !== 1'b0)
         $display("FAIL reset_ready: got %b%b want 00", src_ready, dst_ready); else passed++;
      checks++; if (px_x !== 16'd0 || px_y !== 16'd0)
         $display("FAIL reset_px: got (%0d,%0d) want (0,0)", px_x, px_y); else passed++;
      rst = 0; src_valid = 0; dst_valid = 0;
      @(posedge clk); #1;
      $display("reset released");
   endtask

   task automatic test_opaque;
      int n; bit sd, to, so; int ns;
      drive_job(16'd2, 16'd1, 32'hFF102030, 32'h80A0B0C0, 0, 0, 0, n, sd, to, so, ns);
      checks++; if (to) $display("FAIL opaque_timeout: got timeout want done"); else passed++;
      checks++; if (n !== 2) $display("FAIL opaque_count: got %0d want 2", n); else passed++;
      for (int i = 0; i < 2 && i < n; i++) begin
         checks++; if (out_q[i] !== 32'hFF102030)
            $display("FAIL opaque_data[%0d]: got %08h want FF102030", i, out_q[i]); else passed++;
      end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL opaque_after: got done=%b busy=%b want 0 0", done, busy); else passed++;
   endtask

   task automatic test_transparent;
      int n; bit sd, to, so; int ns;
      drive_job(16'd1, 16'd1, 32'h00FFFFFF, 32'hFF204060, 0, 0, 0, n, sd, to, so, ns);
      checks++; if (n !== 1 || to) $display("FAIL transp_count: got %0d to=%b want 1", n, to); else passed++;
      if (n > 0) begin
         checks++; if (out_q[0] !== 32'hFF204060)
            $display("FAIL transp_data: got %08h want FF204060", out_q[0]); else passed++;
      end
   endtask

   task automatic test_partial_alpha;
      int n; bit sd, to, so; int ns;
      // a=255-((128*191)>>8)=A0; r=(128*16+32*129)>>8=18; g=30; b=48
      drive_job(16'd1, 16'd1, 32'h80204060, 32'h40102030, 0, 0, 0, n, sd, to, so, ns);
      checks++; if (n !== 1 || out_q.size() == 0 || out_q[0] !== 32'hA0183048)
         $display("FAIL half_alpha: got n=%0d data=%08h want A0183048", n, (n > 0) ? out_q[0] : 32'h0); else passed++;
      // r=(255*129)>>8=80, b=(128*255)>>8=7F
      drive_job(16'd1, 16'd1, 32'h80FF0000, 32'hFF0000FF, 0, 0, 0, n, sd, to, so, ns);
      checks++; if (n !== 1 || out_q.size() == 0 || out_q[0] !== 32'hFF80007F)
         $display("FAIL half_mix: got n=%0d data=%08h want FF80007F", n, (n > 0) ? out_q[0] : 32'h0); else passed++;
   endtask

   task automatic test_back_pressure;
      int n; bit sd, to, so; int ns;
      drive_job(16'd4, 16'd2, 32'hFF000000, 32'h12345678, 1, 3, 3, n, sd, to, so, ns);
      checks++; if (to) $display("FAIL bp_timeout: got timeout want done"); else passed++;
      checks++; if (n !== 8) $display("FAIL bp_count: got %0d want 8", n); else passed++;
      for (int i = 0; i < 8 && i < n; i++) begin
         checks++; if (out_q[i] !== (32'hFF000000 + 32'(i)))
            $display("FAIL bp_order[%0d]: got %08h want %08h", i, out_q[i], 32'hFF000000 + 32'(i)); else passed++;
      end
      checks++; if (!so) $display("FAIL bp_stall_stable: got unstable/ready want stable, ready low"); else passed++;
      checks++; if (ns !== 3) $display("FAIL bp_stall_cycles: got %0d want 3", ns); else passed++;
   endtask

   task automatic test_zero_size;
      bit rdy_seen = 0;
      @(posedge clk); #1;
      start = 1; width = 16'd0; height = 16'd5;
      src_valid = 1; dst_valid = 1; src_data = 32'hFFFFFFFF; dst_data = 32'h0;
      #1; rdy_seen = rdy_seen | src_ready;
      @(posedge clk); #1;
      start = 0;
      #1; rdy_seen = rdy_seen | src_ready;
      checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else passed++;
      @(posedge clk); #2;
      rdy_seen = rdy_seen | src_ready;
      checks++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done); else passed++;
      checks++; if (rdy_seen) $display("FAIL zero_src_ready: got 1 want never high"); else passed++;
      src_valid = 0; dst_valid = 0;
      $display("zero-size job complete");
   endtask

   task automatic test_wrap;
      logic [15:0] xs [6];
      logic [15:0] ys [6];
      int fires = 0;
      bit ok = 1;
      xs = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2};
      ys = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
      @(posedge clk); #1;
      start = 1; width = 16'd3; height = 16'd2; out_ready = 1;
      @(posedge clk); #1;
      start = 0; src_valid = 1; dst_valid = 1; src_data = 32'hFF010203; dst_data = 32'h0;
      for (int cyc = 0; cyc < 40 && fires < 6; cyc++) begin
         #1;
         if (src_ready) begin
            $display("fire (%0d,%0d)", px_x, px_y);
            if (px_x !== xs[fires] || px_y !== ys[fires]) begin
               $display("FAIL wrap_px[%0d]: got (%0d,%0d) want (%0d,%0d)", fires, px_x, px_y, xs[fires], ys[fires]);
               ok = 0;
            end
            fires++;
         end
         @(posedge clk); #1;
      end
      src_valid = 0; dst_valid = 0;
      checks++; if (fires !== 6) $display("FAIL wrap_fires: got %0d want 6", fires); else passed++;
      checks++; if (!ok) $display("FAIL wrap_sequence: got wrong coordinates want listed order"); else passed++;
      #1;
      checks++; if (busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL wrap_drain: got busy=%b done=%b ov=%b want 1 0 1", busy, done, out_valid); else passed++;
      @(posedge clk); #1;
      checks++; if (done !== 1'b1) $display("FAIL wrap_done: got %b want 1", done); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_job;
      int fires = 0;
      bit done_seen = 0;
      int n; bit sd, to, so; int ns;
      @(posedge clk); #1;
      start = 1; width = 16'd4; height = 16'd4; out_ready = 1;
      @(posedge clk); #1;
      start = 0; src_valid = 1; dst_valid = 1; src_data = 32'hFF445566; dst_data = 32'h0;
      for (int cyc = 0; cyc < 40 && fires < 3; cyc++) begin
         #1;
         if (src_ready) fires++;
         if (fires == 3) rst = 1;
         @(posedge clk); #1;
      end
      rst = 0; src_valid = 0; dst_valid = 0;
      checks++; if (fires !== 3) $display("FAIL mid_fires: got %0d want 3", fires); else passed++;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL mid_idle: got ov=%b busy=%b want 0 0", out_valid, busy); else passed++;
      for (int i = 0; i < 5; i++) begin
         if (done) done_seen = 1;
         @(posedge clk); #1;
      end
      checks++; if (done_seen) $display("FAIL mid_no_done: got done pulse want none"); else passed++;
      drive_job(16'd1, 16'd1, 32'hFF0A0B0C, 32'h0, 0, 0, 0, n, sd, to, so, ns);
      checks++; if (n !== 1 || !sd || out_q.size() == 0 || out_q[0] !== 32'hFF0A0B0C)
         $display("FAIL mid_followup: got n=%0d done=%b want 1 output FF0A0B0C and done", n, sd); else passed++;
   endtask

   initial begin
      test_reset();
      test_opaque();
      test_transparent();
      test_partial_alpha();
      test_back_pressure();
      test_zero_size();
      test_wrap();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
